// File: rtl/enemy_move_sched.sv
// ============================================================================
// Module   : enemy_move_sched
// Purpose  : Walks active enemy slots in ascending order once per move tick and
//            issues one request per slot to a shared position-update datapath.
//            Optional macro ENEMY_MOVE_SCHED_FREEZE_EN adds a freeze input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module enemy_move_sched #(
   parameter int N_SLOTS  = 8,
   parameter int PEND_MAX = 3
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              tick,
   input  logic [N_SLOTS-1:0]                active,
`ifdef ENEMY_MOVE_SCHED_FREEZE_EN
   input  logic                              freeze,
`endif
   output logic                              upd_req,
   output logic [$clog2(N_SLOTS)-1:0]        upd_slot,
   input  logic                              upd_ack,
   output logic                              busy,
   output logic                              sweep_done,
   output logic [$clog2(PEND_MAX+1)-1:0]     pend,
   output logic                              overrun
);

   localparam int c_iw = $clog2(N_SLOTS);
   localparam int c_sw = c_iw + 1;
   localparam int c_pw = $clog2(PEND_MAX + 1);
   localparam logic [c_pw-1:0] c_pend_max = c_pw'(PEND_MAX);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEEK = 2'd1,
      REQ  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            r_state;
   logic [c_sw-1:0]   r_scan;

   logic              w_freeze;
   logic              w_start;
   logic              w_take;
   logic              w_inc;
   logic              w_found;
   logic [c_iw-1:0]   w_found_idx;

`ifdef ENEMY_MOVE_SCHED_FREEZE_EN
   assign w_freeze = freeze;
`else
   assign w_freeze = 1'b0;
`endif

   // A tick arriving with nothing stored is used directly and never enters pend.
   assign w_start = (r_state == IDLE) && (tick || (pend != '0)) && !w_freeze;
   assign w_take  = w_start && (pend != '0);
   assign w_inc   = tick && !(w_start && (pend == '0));

   // Descending walk so the lowest qualifying slot is the last one written.
   always_comb begin
      w_found     = 1'b0;
      w_found_idx = '0;
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         if (active[i] && (i >= int'(r_scan))) begin
            w_found     = 1'b1;
            w_found_idx = c_iw'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_scan     <= '0;
         upd_req    <= 1'b0;
         upd_slot   <= '0;
         busy       <= 1'b0;
         sweep_done <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_state <= SEEK;
                  r_scan  <= '0;
                  busy    <= 1'b1;
               end
            end
            SEEK: begin
               if (w_found) begin
                  r_state  <= REQ;
                  upd_slot <= w_found_idx;
                  upd_req  <= 1'b1;
               end else begin
                  r_state    <= DONE;
                  sweep_done <= 1'b1;
               end
            end
            REQ: begin
               if (upd_ack) begin
                  r_state <= SEEK;
                  r_scan  <= c_sw'({1'b0, upd_slot}) + c_sw'(1);
                  upd_req <= 1'b0;
               end
            end
            DONE: begin
               r_state    <= IDLE;
               sweep_done <= 1'b0;
               busy       <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend    <= '0;
         overrun <= 1'b0;
      end else if (w_inc && !w_take) begin
         if (pend == c_pend_max) begin
            overrun <= 1'b1;
         end else begin
            pend <= pend + c_pw'(1);
         end
      end else if (w_take && !w_inc) begin
         pend <= pend - c_pw'(1);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_enemy_move_sched.sv
// ============================================================================
// Module   : tb_enemy_move_sched
// Purpose  : Directed and randomized bench for enemy_move_sched with a
//            behavioural model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enemy_move_sched;

   localparam int N    = 8;
   localparam int PMAX = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic [7:0] active = '0;
   logic       upd_ack = 1'b0;
   logic       frz = 1'b0;
   logic       upd_req;
   logic [2:0] upd_slot;
   logic       busy;
   logic       sweep_done;
   logic [1:0] pend;
   logic       overrun;

   always #5 clk = ~clk;

   enemy_move_sched #(.N_SLOTS(N), .PEND_MAX(PMAX)) dut (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .active     (active),
`ifdef ENEMY_MOVE_SCHED_FREEZE_EN
      .freeze     (frz),
`endif
      .upd_req    (upd_req),
      .upd_slot   (upd_slot),
      .upd_ack    (upd_ack),
      .busy       (busy),
      .sweep_done (sweep_done),
      .pend       (pend),
      .overrun    (overrun)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // Model: phase 0 idle, 1 looking for next slot, 2 waiting for accept, 3 finishing.
   int m_ph = 0, m_scan = 0, m_slot = 0, m_pend = 0, m_ovr = 0;
   int np, nxt, start;

   always @(posedge clk) begin
      if (reset) begin
         m_ph = 0; m_scan = 0; m_slot = 0; m_pend = 0; m_ovr = 0;
      end else begin
         start = (m_ph == 0 && (m_pend > 0 || tick) && !frz) ? 1 : 0;
         np = m_pend + int'(tick) - start;
         if (np > PMAX) begin
            np = PMAX;
            m_ovr = 1;
         end
         m_pend = np;
         if (m_ph == 0) begin
            if (start == 1) begin m_ph = 1; m_scan = 0; end
         end else if (m_ph == 1) begin
            nxt = -1;
            for (int i = 0; i < N; i++)
               if (nxt < 0 && i >= m_scan && active[i]) nxt = i;
            if (nxt >= 0) begin m_ph = 2; m_slot = nxt; end
            else m_ph = 3;
         end else if (m_ph == 2) begin
            if (upd_ack) begin m_ph = 1; m_scan = m_slot + 1; end
         end else begin
            m_ph = 0;
         end
      end
   end

   int dut_last = -1;

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("upd_req",    int'(upd_req),    (m_ph == 2) ? 1 : 0);
         chk("upd_slot",   int'(upd_slot),   m_slot);
         chk("busy",       int'(busy),       (m_ph != 0) ? 1 : 0);
         chk("sweep_done", int'(sweep_done), (m_ph == 3) ? 1 : 0);
         chk("pend",       int'(pend),       m_pend);
         chk("overrun",    int'(overrun),    m_ovr);
         if (sweep_done || reset) dut_last = -1;
         else if (upd_req && upd_ack) begin
            chk("ascending", (int'(upd_slot) > dut_last) ? 1 : 0, 1);
            dut_last = int'(upd_slot);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   int seq[8];
   int nseq, dn;

   initial begin
      reset = 1'b1;
      cyc(1);
      cmp_en = 1'b1;
      cyc(1);
      chk("rst_upd_req", int'(upd_req), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pend", int'(pend), 0);
      chk("rst_overrun", int'(overrun), 0);
      reset = 1'b0;
      cyc(2);

      // Four active slots, immediate ack
      active = 8'b1010_0101; upd_ack = 1'b1;
      tick = 1'b1; cyc(1); tick = 1'b0;
      nseq = 0; dn = 0;
      for (int k = 0; k < 20; k++) begin
         cyc(1);
         if (upd_req && nseq < 8) begin seq[nseq] = int'(upd_slot); nseq++; end
         if (sweep_done) dn++;
      end
      chk("a5_count", nseq, 4);
      chk("a5_s0", seq[0], 0);
      chk("a5_s1", seq[1], 2);
      chk("a5_s2", seq[2], 5);
      chk("a5_s3", seq[3], 7);
      chk("a5_done", dn, 1);
      chk("a5_pend", int'(pend), 0);

      // Empty sweep timing
      active = 8'h00;
      tick = 1'b1; cyc(1); tick = 1'b0;
      chk("empty_busy1", int'(busy), 1);
      chk("empty_done1", int'(sweep_done), 0);
      cyc(1);
      chk("empty_done2", int'(sweep_done), 1);
      chk("empty_busy2", int'(busy), 1);
      chk("empty_req2", int'(upd_req), 0);
      cyc(1);
      chk("empty_busy3", int'(busy), 0);
      chk("empty_done3", int'(sweep_done), 0);

      // Delayed ack holds request
      active = 8'h01; upd_ack = 1'b0;
      tick = 1'b1; cyc(1); tick = 1'b0;
      cyc(1);
      for (int k = 0; k < 5; k++) begin
         chk("hold_req", int'(upd_req), 1);
         chk("hold_slot", int'(upd_slot), 0);
         if (k < 4) cyc(1);
      end
      upd_ack = 1'b1; cyc(1); upd_ack = 1'b0;
      chk("hold_release", int'(upd_req), 0);
      cyc(3);

      // Saturating pending ticks while a sweep is stalled
      tick = 1'b1; cyc(1); tick = 1'b0;
      cyc(1);
      tick = 1'b1; cyc(4); tick = 1'b0;
      chk("sat_pend", int'(pend), 3);
      chk("sat_model_pend", m_pend, 3);
      chk("sat_ovr", int'(overrun), 1);
      upd_ack = 1'b1; dn = 0;
      for (int k = 0; k < 30; k++) begin
         cyc(1);
         if (sweep_done) dn++;
      end
      chk("sat_sweeps", dn, 4);
      chk("sat_pend_end", int'(pend), 0);
      chk("sat_ovr_end", int'(overrun), 1);
      upd_ack = 1'b0;

      // Reset mid-request
      tick = 1'b1; cyc(1); tick = 1'b0;
      cyc(1);
      tick = 1'b1; cyc(1); tick = 1'b0;
      chk("mid_req", int'(upd_req), 1);
      chk("mid_pend", int'(pend), 1);
      reset = 1'b1; cyc(1); reset = 1'b0;
      chk("mid_rst_req", int'(upd_req), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_pend", int'(pend), 0);
      chk("mid_rst_ovr", int'(overrun), 0);
      chk("mid_rst_model_ovr", m_ovr, 0);
      upd_ack = 1'b1;
      tick = 1'b1; cyc(1); tick = 1'b0;
      cyc(1);
      chk("restart_req", int'(upd_req), 1);
      chk("restart_slot", int'(upd_slot), 0);
      cyc(5);

`ifdef ENEMY_MOVE_SCHED_FREEZE_EN
      frz = 1'b1; active = 8'hFF;
      tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
      tick = 1'b1; cyc(1); tick = 1'b0; cyc(3);
      chk("frz_busy", int'(busy), 0);
      chk("frz_pend", int'(pend), 2);
      frz = 1'b0; dn = 0;
      for (int k = 0; k < 60; k++) begin
         cyc(1);
         if (sweep_done) dn++;
      end
      chk("frz_sweeps", dn, 2);
      chk("frz_pend_end", int'(pend), 0);
`endif

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         active  = 8'($urandom);
         tick    = ($urandom_range(0, 5) == 0);
         upd_ack = 1'($urandom_range(0, 1));
         reset   = ($urandom_range(0, 299) == 0);
`ifdef ENEMY_MOVE_SCHED_FREEZE_EN
         if ($urandom_range(0, 49) == 0) frz = ~frz;
`endif
         cyc(1);
      end
      reset = 1'b0; tick = 1'b0; upd_ack = 1'b0; frz = 1'b0;
      cyc(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
